// File: rtl/uart_pkg.sv
// Constants shared between the UART controller and its receive-side buffering.
package uart_pkg;

  // Word width assembled by the controller from a byte pair.
  localparam int UART_WORD_W = 16;

  localparam int UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage for the UART receive FIFO: one write port, one
// combinational read address. Storage is deliberately not reset.
module uart_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART controller and a host-side consumer.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W   = UART_WORD_W,
  parameter int DEPTH    = UART_RX_FIFO_DEPTH,
  parameter int AFULL_TH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [ADDR_W:0]  PTR_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFTH  = CNT_W'(AFULL_TH);

  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               afull_q, afull_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               wr_acc, rd_acc;
  logic [DATA_W-1:0]  mem_rdata;

  // Accepts are gated by the registered flags only, so a write while full is
  // dropped even if a read frees a slot in the same cycle.
  always_comb begin
    wr_acc   = wr_en & ~full_q;
    rd_acc   = rd_en & ~empty_q;
    wr_ptr_d = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_acc ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_DEPTH);
    empty_d = (count_d == '0);
    afull_d = (count_d >= CNT_AFTH);
    // A new error event outranks a coincident clear.
    ovf_d   = (ovf_q & ~clr_err) | (wr_en & full_q);
    unf_d   = (unf_q & ~clr_err) | (rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

`ifdef UART_RX_FIFO_FWFT_EN
  // Masked while empty so stale array contents never leak out after reset.
  assign rd_data  = empty_q ? '0 : mem_rdata;
  assign rd_valid = ~empty_q;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full        = full_q;
  assign almost_full = afull_q;
  assign empty       = empty_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based model of the FIFO.
module tb_uart_rx_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFTH  = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic          full, almost_full, rd_valid, empty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model state
  logic [DW-1:0] exp_q[$];
  bit            m_ovf, m_unf, m_rv;
  logic [DW-1:0] m_rd;
  bit            was_full, was_empty, do_pop, do_push;

  uart_rx_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words, flags derived from its size.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = '0;
    end else begin
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      do_pop    = rd_en && !was_empty;
      do_push   = wr_en && !was_full;
      m_rv      = do_pop;
      if (do_pop) m_rd = exp_q.pop_front();
      if (do_push) exp_q.push_back(wr_data);
      m_ovf = (wr_en && was_full) || (m_ovf && !clr_err);
      m_unf = (rd_en && was_empty) || (m_unf && !clr_err);
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(exp_q.size()));
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("almost_full", 32'(almost_full), 32'(exp_q.size() >= AFTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
`ifdef UART_RX_FIFO_FWFT_EN
      check("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      check("rd_data", 32'(rd_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
`else
      check("rd_valid", 32'(rd_valid), 32'(m_rv));
      check("rd_data", 32'(rd_data), 32'(m_rd));
`endif
    end
  end

  // Driver: apply inputs for one cycle, return at the following negedge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    @(posedge clk);
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  // Pop one word and check it against a literal, honouring the read mode.
  task automatic read_expect(input string name, input logic [DW-1:0] exp);
`ifdef UART_RX_FIFO_FWFT_EN
    check(name, 32'(rd_data), 32'(exp));
    step(1'b0, '0, 1'b1, 1'b0);
`else
    step(1'b0, '0, 1'b1, 1'b0);
    check(name, 32'(rd_data), 32'(exp));
`endif
  endtask

  initial begin
    int wr_pct, rd_pct;

    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    check("reset_count", 32'(count), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);

    // Single word round trip
    step(1'b1, 16'hA55A, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_FWFT_EN
    check("s1_fwft_valid", 32'(rd_valid), 32'd1);
    check("s1_fwft_data", 32'(rd_data), 32'hA55A);
    step(1'b0, '0, 1'b1, 1'b0);
`else
    step(1'b0, '0, 1'b1, 1'b0);
    check("s1_valid", 32'(rd_valid), 32'd1);
    check("s1_data", 32'(rd_data), 32'hA55A);
`endif
    check("s1_empty", 32'(empty), 32'd1);
    check("s1_count", 32'(count), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("s1_valid_drop", 32'(rd_valid), 32'd0);

    // Fill to full, watch almost_full and full thresholds
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == AFTH - 2) check("s2_af_below", 32'(almost_full), 32'd0);
      if (i == AFTH - 1) check("s2_af_at", 32'(almost_full), 32'd1);
      if (i == DEPTH - 2) check("s2_full_below", 32'(full), 32'd0);
    end
    check("s2_full", 32'(full), 32'd1);
    check("s2_count", 32'(count), 32'd16);

    // Overflow while full, then clear
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("s3_overflow", 32'(overflow), 32'd1);
    check("s3_count", 32'(count), 32'd16);
    step(1'b0, '0, 1'b0, 1'b1);
    check("s3_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) read_expect("s2_drain", DW'(i));
    check("s2_count_end", 32'(count), 32'd0);

    // Read and write together while empty
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    check("s4_underflow", 32'(underflow), 32'd1);
    check("s4_count", 32'(count), 32'd1);
    read_expect("s4_data", 16'h1234);
    step(1'b0, '0, 1'b0, 1'b1);
    check("s4_clr", 32'(underflow), 32'd0);

    // Steady occupancy of 5 with pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
    check("s5_count", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-operation
    for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    check("s6_count_pre", 32'(count), 32'd7);
    rst = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    check("s6_empty", 32'(empty), 32'd1);
    check("s6_count", 32'(count), 32'd0);
    check("s6_full", 32'(full), 32'd0);
    check("s6_overflow", 32'(overflow), 32'd0);
    check("s6_rd_valid", 32'(rd_valid), 32'd0);

    // Randomized traffic in phases biased toward filling or draining
    wr_pct = 50;
    rd_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        wr_pct = $urandom_range(95, 5);
        rd_pct = $urandom_range(95, 5);
      end
      rst = ($urandom_range(499, 0) == 0);
      step($urandom_range(99, 0) < wr_pct, DW'($urandom),
           $urandom_range(99, 0) < rd_pct, $urandom_range(99, 0) < 3);
      rst = 1'b0;
    end

    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
